// File: rtl/led_frame_arbiter.sv
// Round-robin frame arbiter for a two-wire serial LED strip: grants one of two
// frame sources and shifts out start frame, NUM_LEDS pixel words and an end frame.
module led_frame_arbiter #(
  parameter int NUM_LEDS = 64,
  parameter int END_BITS = 64,   // 1..64, counted by the 6-bit bit counter
  parameter int CLK_DIV  = 1,
  localparam int IW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    req,
  output logic [1:0]    gnt,
  output logic [IW-1:0] pix_idx,
  input  logic [31:0]   pix_data0,
  input  logic [31:0]   pix_data1,
  output logic          led_clk,
  output logic          led_dat,
  output logic          busy,
  output logic          frame_done
);

  localparam int PW = $clog2(CLK_DIV) + 1;
  localparam int WW = IW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_PIXELS, ST_END} state_t;

  state_t        state_reg;
  logic [PW-1:0] phase_reg;
  logic          high_reg;
  logic [5:0]    bit_reg;
  logic [WW-1:0] word_reg;
  logic [31:0]   shift_reg;
  logic          last_reg;

  logic [31:0] pix_src    [2];
  logic [31:0] pix_masked [2];
  logic [31:0] pix_word;
  logic [1:0]  grant_pick;
  logic        phase_end;

  assign pix_src[0] = pix_data0;
  assign pix_src[1] = pix_data1;

  // One-hot grant selects the word; both terms are zero while idle.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_pix_mux
      assign pix_masked[gi] = gnt[gi] ? pix_src[gi] : 32'h0;
    end
  endgenerate

  assign pix_word  = pix_masked[0] | pix_masked[1];
  assign phase_end = (phase_reg == PW'(CLK_DIV - 1));

  // On a tie the source that was not granted last wins.
  always_comb begin
    grant_pick = 2'b00;
    if (req == 2'b11)
      grant_pick = last_reg ? 2'b01 : 2'b10;
    else
      grant_pick = req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      phase_reg  <= '0;
      high_reg   <= 1'b0;
      bit_reg    <= '0;
      word_reg   <= '0;
      shift_reg  <= '0;
      last_reg   <= 1'b1;
      gnt        <= 2'b00;
      pix_idx    <= '0;
      led_clk    <= 1'b0;
      led_dat    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state_reg == ST_IDLE) begin
        if (req != 2'b00) begin
          gnt       <= grant_pick;
          busy      <= 1'b1;
          state_reg <= ST_START;
          phase_reg <= '0;
          high_reg  <= 1'b0;
          bit_reg   <= '0;
          word_reg  <= '0;
          pix_idx   <= '0;
          shift_reg <= '0;
          led_clk   <= 1'b0;
          led_dat   <= 1'b0;
        end
      end else if (!phase_end) begin
        phase_reg <= phase_reg + 1'b1;
      end else begin
        phase_reg <= '0;
        if (!high_reg) begin
          high_reg <= 1'b1;
          led_clk  <= 1'b1;
          // Advance the fetch index a half bit early so the source has a full phase of setup.
          if (state_reg == ST_PIXELS && bit_reg == 6'd31) begin
            word_reg <= word_reg + 1'b1;
            pix_idx  <= (word_reg == WW'(NUM_LEDS - 1)) ? '0 : pix_idx + 1'b1;
          end
        end else begin
          high_reg <= 1'b0;
          led_clk  <= 1'b0;
          if (state_reg == ST_START) begin
            if (bit_reg == 6'd31) begin
              state_reg <= ST_PIXELS;
              bit_reg   <= '0;
              shift_reg <= pix_word;
              led_dat   <= pix_word[31];
            end else begin
              bit_reg <= bit_reg + 1'b1;
            end
          end else if (state_reg == ST_PIXELS) begin
            if (bit_reg == 6'd31) begin
              bit_reg <= '0;
              if (word_reg == WW'(NUM_LEDS)) begin
                state_reg <= ST_END;
                shift_reg <= '0;
                led_dat   <= 1'b0;
              end else begin
                shift_reg <= pix_word;
                led_dat   <= pix_word[31];
              end
            end else begin
              bit_reg   <= bit_reg + 1'b1;
              shift_reg <= {shift_reg[30:0], 1'b0};
              led_dat   <= shift_reg[30];
            end
          end else begin
            if (bit_reg == 6'(END_BITS - 1)) begin
              state_reg  <= ST_IDLE;
              gnt        <= 2'b00;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              last_reg   <= gnt[1];
              bit_reg    <= '0;
            end else begin
              bit_reg <= bit_reg + 1'b1;
            end
          end
        end
      end
    end
  end

endmodule
